// File: rtl/nios2_mul_pkg.sv
// Shared types and constants for the 32x32 multiply sequencer that drives
// the three-output 16x16 partial-product cell.
package nios2_mul_pkg;

    // Operand half width seen by the partial-product cell; a full word is two halves.
    localparam int HALF_W = 16;
    localparam int WORD_W = 2 * HALF_W;

    // Multiply flavours; OP_MUL returns the low word, the MULX ops the high word.
    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULXUU = 2'b01,
        OP_MULXSS = 2'b10,
        OP_MULXSU = 2'b11
    } mul_op_e;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE_LO = 3'd1,
        ST_ISSUE_HI = 3'd2,
        ST_ACCUM    = 3'd3,
        ST_DONE     = 3'd4
    } seq_state_e;

endpackage

// File: rtl/nios2_mul_combine.sv
// Combines the four 16x16 partial products into the 64-bit unsigned product
// and returns either its low word (MUL) or its high word with the signed
// correction terms applied (MULXUU / MULXSS / MULXSU).
module nios2_mul_combine
    import nios2_mul_pkg::*;
(
    input  logic [WORD_W-1:0] i_ll,
    input  logic [WORD_W-1:0] i_lh,
    input  logic [WORD_W-1:0] i_hl,
    input  logic [WORD_W-1:0] i_hh,
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    input  mul_op_e           i_op,
    output logic [WORD_W-1:0] o_result
);

    logic [WORD_W:0]     w_mid;
    logic [2*WORD_W-1:0] w_full;
    logic [WORD_W-1:0]   w_hi;
    logic [WORD_W-1:0]   w_corr_a;
    logic [WORD_W-1:0]   w_corr_b;

    // Sum the partial products and select / sign-correct the requested word.
    always_comb begin
        // NOTE: every output of this block is assigned before any branch so no latch is inferred.
        o_result = '0;
        // The middle sum is one bit wider than a word; its carry lands in bit 48 of the product.
        w_mid    = {1'b0, i_lh} + {1'b0, i_hl};
        w_full   = {i_hh, {WORD_W{1'b0}}}
                 + ({{(WORD_W-1){1'b0}}, w_mid} << HALF_W)
                 + {{WORD_W{1'b0}}, i_ll};
        w_hi     = w_full[2*WORD_W-1:WORD_W];
        // A negative signed operand contributes -2^32 times the other operand to the product.
        w_corr_a = i_a[WORD_W-1] ? i_b : '0;
        w_corr_b = i_b[WORD_W-1] ? i_a : '0;
        case (i_op)
            OP_MUL:    o_result = w_full[WORD_W-1:0];
            OP_MULXUU: o_result = w_hi;
            OP_MULXSS: o_result = w_hi - w_corr_a - w_corr_b;
            OP_MULXSU: o_result = w_hi - w_corr_a;
            default:   o_result = w_full[WORD_W-1:0];
        endcase
    end

endmodule

// File: rtl/nios2_mult_cell_seq.sv
// Sequencer between the multiply front end and the 16x16 partial-product
// cell. One request is accepted in IDLE, issued to the cell once (MUL) or
// twice (MULX), combined, and held on the response port until consumed.
module nios2_mult_cell_seq
    import nios2_mul_pkg::*;
#(
    parameter bit SUPPORT_MULX = 1'b1
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              abort,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [WORD_W-1:0] req_a,
    input  logic [WORD_W-1:0] req_b,
    input  logic [1:0]        req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_data,
    output logic [WORD_W-1:0] cell_src1,
    output logic [WORD_W-1:0] cell_src2,
    output logic              cell_en,
    input  logic [WORD_W-1:0] cell_p1,
    input  logic [WORD_W-1:0] cell_p2,
    input  logic [WORD_W-1:0] cell_p3
);

    seq_state_e        r_state;
    mul_op_e           r_op;
    logic [WORD_W-1:0] r_a;
    logic [WORD_W-1:0] r_b;
    logic [WORD_W-1:0] r_ll;
    logic [WORD_W-1:0] r_lh;
    logic [WORD_W-1:0] r_hl;
    logic [WORD_W-1:0] r_cell_src1;
    logic [WORD_W-1:0] r_cell_src2;
    logic              r_cell_en;
    logic              r_rsp_valid;
    logic [WORD_W-1:0] r_rsp_data;

    logic              w_req_ready;
    logic              w_is_mulx;
    logic              w_cell_en;
    logic [WORD_W-1:0] w_ll;
    logic [WORD_W-1:0] w_lh;
    logic [WORD_W-1:0] w_hl;
    logic [WORD_W-1:0] w_hh;
    logic [WORD_W-1:0] w_result;

    // An abort suppresses both acceptance and the cell enable in the cycle it is seen.
    assign w_req_ready = (r_state == ST_IDLE) && !abort;
    assign w_cell_en   = r_cell_en && !abort;
    assign w_is_mulx   = (r_op != OP_MUL);

    // MUL combines the single issue straight off the cell; MULX uses the
    // first issue from the capture registers and hi*hi from the cell's p1.
    assign w_ll = w_is_mulx ? r_ll    : cell_p1;
    assign w_lh = w_is_mulx ? r_lh    : cell_p2;
    assign w_hl = w_is_mulx ? r_hl    : cell_p3;
    assign w_hh = w_is_mulx ? cell_p1 : '0;

    nios2_mul_combine u_combine (
        .i_ll     (w_ll),
        .i_lh     (w_lh),
        .i_hl     (w_hl),
        .i_hh     (w_hh),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (r_op),
        .o_result (w_result)
    );

    // Sequencer FSM with registered cell controls and response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: every register, operand latches included, is reset so no X reaches the cell or the response port.
            r_state     <= ST_IDLE;
            r_op        <= OP_MUL;
            r_a         <= '0;
            r_b         <= '0;
            r_ll        <= '0;
            r_lh        <= '0;
            r_hl        <= '0;
            r_cell_src1 <= '0;
            r_cell_src2 <= '0;
            r_cell_en   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else if (abort) begin
            // NOTE: non-blocking assignments keep every register update in this block based on pre-edge values.
            r_state     <= ST_IDLE;
            r_cell_src1 <= '0;
            r_cell_src2 <= '0;
            r_cell_en   <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && w_req_ready) begin
                        r_a         <= req_a;
                        r_b         <= req_b;
                        r_op        <= SUPPORT_MULX ? mul_op_e'(req_op) : OP_MUL;
                        r_cell_src1 <= req_a;
                        r_cell_src2 <= req_b;
                        r_cell_en   <= 1'b1;
                        r_state     <= ST_ISSUE_LO;
                    end
                end
                ST_ISSUE_LO: begin
                    if (w_is_mulx) begin
                        r_cell_src1 <= {{HALF_W{1'b0}}, r_a[WORD_W-1:HALF_W]};
                        r_cell_src2 <= {{HALF_W{1'b0}}, r_b[WORD_W-1:HALF_W]};
                        r_cell_en   <= 1'b1;
                        r_state     <= ST_ISSUE_HI;
                    end else begin
                        r_cell_src1 <= '0;
                        r_cell_src2 <= '0;
                        r_cell_en   <= 1'b0;
                        r_state     <= ST_ACCUM;
                    end
                end
                ST_ISSUE_HI: begin
                    r_ll        <= cell_p1;
                    r_lh        <= cell_p2;
                    r_hl        <= cell_p3;
                    r_cell_src1 <= '0;
                    r_cell_src2 <= '0;
                    r_cell_en   <= 1'b0;
                    r_state     <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    r_rsp_data  <= w_result;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_cell_en   <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign cell_en   = w_cell_en;
    assign cell_src1 = {WORD_W{w_cell_en}} & r_cell_src1;
    assign cell_src2 = {WORD_W{w_cell_en}} & r_cell_src2;

endmodule

// File: tb/tb_nios2_mult_cell_seq.sv
// Self-checking bench for nios2_mult_cell_seq: models the 16x16 cell,
// drives directed and random requests, and compares every response with a
// plain 64-bit arithmetic reference.
module tb_nios2_mult_cell_seq;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        abort;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [1:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] cell_src1;
    logic [31:0] cell_src2;
    logic        cell_en;
    logic [31:0] cell_p1 = '0;
    logic [31:0] cell_p2 = '0;
    logic [31:0] cell_p3 = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nios2_mult_cell_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .abort     (abort),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .cell_src1 (cell_src1),
        .cell_src2 (cell_src2),
        .cell_en   (cell_en),
        .cell_p1   (cell_p1),
        .cell_p2   (cell_p2),
        .cell_p3   (cell_p3)
    );

    // Registered, enable-gated 16x16 partial-product cell.
    always @(posedge clk) begin
        if (cell_en) begin
            cell_p1 <= {16'd0, cell_src1[15:0]}  * {16'd0, cell_src2[15:0]};
            cell_p2 <= {16'd0, cell_src1[15:0]}  * {16'd0, cell_src2[31:16]};
            cell_p3 <= {16'd0, cell_src1[31:16]} * {16'd0, cell_src2[15:0]};
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: extend operands to 64 bits by signedness, multiply, pick a word.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa;
        logic [63:0] xb;
        logic [63:0] p;
        xa = {32'd0, a};
        xb = {32'd0, b};
        if (op == 2'b10 || op == 2'b11) xa = {{32{a[31]}}, a};
        if (op == 2'b10)                xb = {{32{b[31]}}, b};
        p = xa * xb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // One full transaction; starts and ends 1 ns after a rising edge with the DUT idle.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
        logic [31:0] exp_data;
        int          lat;
        logic [7:0]  en_mask;
        logic [31:0] s1_lo, s2_lo, s1_hi, s2_hi;
        exp_data  = ref_mul(op, a, b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        rsp_ready = (stall == 0);
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; en_mask = '0;
        s1_lo = '0; s2_lo = '0; s1_hi = '0; s2_hi = '0;
        @(negedge clk);
        while (!rsp_valid && lat < TIMEOUT) begin
            en_mask[lat] = cell_en;
            if (lat == 0) begin s1_lo = cell_src1; s2_lo = cell_src2; end
            if (lat == 1) begin s1_hi = cell_src1; s2_hi = cell_src2; end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", lat, (op == 2'b00) ? 2 : 3);
        check("rsp_data", rsp_data, exp_data);
        check("cell_en_pattern", en_mask, (op == 2'b00) ? 8'b01 : 8'b11);
        check("issue_lo_src", {s1_lo, s2_lo}, {a, b});
        if (op != 2'b00)
            check("issue_hi_src", {s1_hi, s2_hi}, {16'd0, a[31:16], 16'd0, b[31:16]});
        // Backpressure window: response held, new requests ignored.
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            req_valid = 1'b1;
            req_a     = ~a;
            req_b     = $urandom;
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_data", rsp_data, exp_data);
            check("hold_req_ready", req_ready, 0);
            check("hold_cell_en", cell_en, 0);
        end
        if (stall > 0) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rsp_valid", rsp_valid, 0);
        check("post_req_ready", req_ready, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] corners [7];
        logic [31:0] ra, rb;
        int          n_rv;
        corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001;
        corners[2] = 32'h7FFF_FFFF; corners[3] = 32'h8000_0000;
        corners[4] = 32'hFFFF_FFFF; corners[5] = 32'h0000_FFFF;
        corners[6] = 32'h0001_0000;

        reset_n = 1'b0; abort = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_op = '0;
        #2;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_cell_en", cell_en, 0);
        check("rst_cell_src", {cell_src1, cell_src2}, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        @(posedge clk); #1;

        // Directed cases.
        do_op(2'b00, 32'h0001_0002, 32'h0003_0004, 0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 0);
        do_op(2'b10, 32'h8000_0000, 32'h8000_0000, 0);
        do_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 5);

        // Abort concurrent with a request in IDLE: not accepted.
        abort = 1'b1; req_valid = 1'b1; req_op = 2'b01;
        req_a = $urandom; req_b = $urandom;
        @(negedge clk);
        check("abort_idle_req_ready", req_ready, 0);
        @(posedge clk); #1;
        abort = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("abort_idle_not_accepted", cell_en, 0);
        @(posedge clk); #1;

        // Abort during the second issue of a MULX.
        req_valid = 1'b1; req_op = 2'b01; req_a = $urandom; req_b = $urandom; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1;
        @(negedge clk);
        check("abort_cell_en", cell_en, 0);
        check("abort_req_ready", req_ready, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_to_idle", req_ready, 1);
        check("abort_after_cell_en", cell_en, 0);
        n_rv = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) n_rv++;
        end
        check("abort_no_rsp", n_rv, 0);
        @(posedge clk); #1;
        do_op(2'b00, 32'd3, 32'd5, 0);

        // Random traffic with occasional corner operands and backpressure.
        for (int k = 0; k < 48; k++) begin
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 6)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 6)] : $urandom;
            do_op(2'($urandom_range(0, 3)), ra, rb, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        // Asynchronous reset in ACCUM discards the operation.
        req_valid = 1'b1; req_op = 2'b00; req_a = $urandom; req_b = $urandom; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("rst_mid_rsp_valid", rsp_valid, 0);
        check("rst_mid_cell_en", cell_en, 0);
        check("rst_mid_rsp_data", rsp_data, 0);
        @(negedge clk);
        reset_n = 1'b1;
        n_rv = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) n_rv++;
        end
        check("rst_mid_no_rsp", n_rv, 0);
        check("rst_mid_req_ready", req_ready, 1);
        @(posedge clk); #1;
        do_op(2'b11, 32'h8000_0001, 32'hFFFF_FFFF, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
